// File: rtl/n_to_w_arb_pkg.sv
// Shared types for the narrow-to-wide packet arbiter.
package n_to_w_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/n_to_w_id_fifo.sv
// Small FIFO holding the source ID that owns each outstanding wide packet.
module n_to_w_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/n_to_w_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one narrow-to-wide converter,
// tracking which source owns each wide packet still in flight.
module n_to_w_pkt_arbiter
    import n_to_w_arb_pkg::*;
#(
    parameter int unsigned NUM_SRCS      = 4,
    parameter int unsigned IN_DATA_W     = 64,
    parameter int unsigned IN_KEEP_W     = IN_DATA_W / 8,
    parameter int unsigned ID_FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRCS-1:0]                 src_arb_val,
    input  logic [NUM_SRCS-1:0][IN_DATA_W-1:0]  src_arb_data,
    input  logic [NUM_SRCS-1:0][IN_KEEP_W-1:0]  src_arb_keep,
    input  logic [NUM_SRCS-1:0]                 src_arb_last,
    output logic [NUM_SRCS-1:0]                 arb_src_rdy,
    output logic                                arb_n_to_w_val,
    output logic [IN_DATA_W-1:0]                arb_n_to_w_data,
    output logic [IN_KEEP_W-1:0]                arb_n_to_w_keep,
    output logic                                arb_n_to_w_last,
    input  logic                                n_to_w_arb_rdy,
    input  logic                                n_to_w_dst_val_mon,
    input  logic                                n_to_w_dst_last_mon,
    input  logic                                dst_n_to_w_rdy_mon,
    output logic                                arb_dst_id_val,
    output logic [$clog2(NUM_SRCS)-1:0]         arb_dst_src_id,
    output logic                                arb_id_err
);
    localparam int unsigned SRC_ID_W = $clog2(NUM_SRCS);

    arb_state_e          state_q, state_d;
    logic [SRC_ID_W-1:0] grant_q, grant_d;
    logic [SRC_ID_W-1:0] last_grant_q, last_grant_d;
    logic                id_err_q, id_err_d;
    logic [SRC_ID_W-1:0] winner;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Search upward from the source after the last grant, wrapping modulo NUM_SRCS.
    always_comb begin
        logic        found;
        int unsigned idx;
        winner = last_grant_q;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NUM_SRCS; i++) begin
            idx = (32'(last_grant_q) + i) % NUM_SRCS;
            if (!found && src_arb_val[SRC_ID_W'(idx)]) begin
                winner = SRC_ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        fifo_push       = 1'b0;
        arb_src_rdy     = '0;
        arb_n_to_w_val  = 1'b0;
        arb_n_to_w_data = src_arb_data[grant_q];
        arb_n_to_w_keep = src_arb_keep[grant_q];
        arb_n_to_w_last = src_arb_last[grant_q];
        case (state_q)
            IDLE: begin
                if ((|src_arb_val) && !fifo_full) begin
                    grant_d   = winner;
                    fifo_push = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                arb_n_to_w_val       = src_arb_val[grant_q];
                arb_src_rdy[grant_q] = n_to_w_arb_rdy;
                if (src_arb_val[grant_q] && n_to_w_arb_rdy && src_arb_last[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d         = arb_state_e'('x);
                grant_d         = 'x;
                last_grant_d    = 'x;
                fifo_push       = 1'bx;
                arb_src_rdy     = 'x;
                arb_n_to_w_val  = 1'bx;
                arb_n_to_w_data = 'x;
                arb_n_to_w_keep = 'x;
                arb_n_to_w_last = 1'bx;
            end
        endcase
    end

    assign fifo_pop = n_to_w_dst_val_mon & dst_n_to_w_rdy_mon & n_to_w_dst_last_mon;
    assign id_err_d = id_err_q | (fifo_pop & fifo_empty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_ID_W'(NUM_SRCS - 1);
            id_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            id_err_q     <= id_err_d;
        end
    end

    n_to_w_id_fifo #(
        .WIDTH (SRC_ID_W),
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (winner),
        .pop       (fifo_pop),
        .head      (arb_dst_src_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign arb_dst_id_val = ~fifo_empty;
    assign arb_id_err     = id_err_q;

endmodule
